// File: rtl/upconvert_mixer.sv
// upconvert_mixer: real passband sample Re{x*NCO} = I*C - Q*S using one time-shared 18x18 multiplier.
// Optional macro DROP_COUNT_EN adds opDropCount (ignored-while-busy samples) and opSatFlag (sticky clamp).
package upconvert_mixer_pkg;
    typedef struct packed {
        logic signed [17:0] I;
        logic signed [17:0] Q;
        logic               Valid;
    } COMPLEX_STREAM;

    typedef struct packed {
        logic signed [15:0] Data;
        logic               Valid;
    } DATA_STREAM;
endpackage

module upconvert_mixer
    import upconvert_mixer_pkg::*;
#(
    parameter int SHIFT = 18
) (
    input  logic          ipClk,
    input  logic          ipReset,
    input  COMPLEX_STREAM ipInput,
    input  COMPLEX_STREAM ipNCO,
    output DATA_STREAM    opOutput,
    output logic          opBusy
`ifdef DROP_COUNT_EN
    ,
    output logic [15:0]   opDropCount,
    output logic          opSatFlag
`endif
);

    typedef enum logic [1:0] {Idle, MulQ, Sub, Done} StateT;

    localparam logic signed [37:0] RoundHalf = 38'sd1 <<< (SHIFT - 1);

    StateT              state;
    StateT              nextState;
    logic               busyReg;
    DATA_STREAM         outReg;
    logic signed [17:0] latQ;
    logic signed [17:0] latNcoQ;
    logic signed [17:0] mulA;
    logic signed [17:0] mulB;
    logic signed [35:0] mulResult;
    logic signed [35:0] prod;
    logic signed [36:0] acc;
    logic signed [37:0] rounded;
    logic signed [37:0] shifted;
    logic signed [15:0] satData;
    logic               satClamp;
    logic               unusedNcoValid;

    assign unusedNcoValid = ipNCO.Valid;
    assign opOutput       = outReg;
    assign opBusy         = busyReg;

    // State register; busy is registered from the next state so it tracks State != Idle.
    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            state   <= Idle;
            busyReg <= 1'b0;
        end else begin
            state   <= nextState;
            busyReg <= (nextState != Idle);
        end
    end

    // Next-state decode; an unreachable encoding falls back to Idle.
    always_comb begin
        nextState = Idle;
        case (state)
            Idle: begin
                if (ipInput.Valid) begin
                    nextState = MulQ;
                end else begin
                    nextState = Idle;
                end
            end
            MulQ:    nextState = Sub;
            Sub:     nextState = Done;
            Done:    nextState = Idle;
            default: nextState = Idle;
        endcase
    end

    // Shared multiplier: I*C straight from the inputs when accepting, latched Q*S afterwards.
    always_comb begin
        mulA = 18'sd0;
        mulB = 18'sd0;
        if (state == Idle) begin
            mulA = ipInput.I;
            mulB = ipNCO.I;
        end else begin
            mulA = latQ;
            mulB = latNcoQ;
        end
        mulResult = mulA * mulB;
    end

    // Round half up in a 38-bit intermediate, arithmetic shift, then clamp to 16 bits.
    always_comb begin
        rounded  = $signed({acc[36], acc}) + RoundHalf;
        shifted  = rounded >>> SHIFT;
        satData  = 16'sd0;
        satClamp = 1'b0;
        if (shifted > 38'sd32767) begin
            satData  = 16'sh7FFF;
            satClamp = 1'b1;
        end else if (shifted < -38'sd32768) begin
            satData  = 16'sh8000;
            satClamp = 1'b1;
        end else begin
            satData  = shifted[15:0];
            satClamp = 1'b0;
        end
    end

    // Datapath and output registers sequenced by the FSM.
    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            outReg  <= '0;
            latQ    <= 18'sd0;
            latNcoQ <= 18'sd0;
            prod    <= 36'sd0;
            acc     <= 37'sd0;
        end else begin
            case (state)
                Idle: begin
                    outReg.Valid <= 1'b0;
                    if (ipInput.Valid) begin
                        latQ    <= ipInput.Q;
                        latNcoQ <= ipNCO.Q;
                        prod    <= mulResult;
                    end
                end
                MulQ: begin
                    acc  <= $signed({prod[35], prod});
                    prod <= mulResult;
                end
                Sub: begin
                    acc <= acc - $signed({prod[35], prod});
                end
                Done: begin
                    outReg.Data  <= satData;
                    outReg.Valid <= 1'b1;
                end
                default: begin
                    outReg.Valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef DROP_COUNT_EN
    logic [15:0] dropCountReg;
    logic        satFlagReg;

    assign opDropCount = dropCountReg;
    assign opSatFlag   = satFlagReg;

    // Saturating count of samples offered while busy, plus sticky clamp flag.
    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            dropCountReg <= 16'd0;
            satFlagReg   <= 1'b0;
        end else begin
            if (ipInput.Valid && (state != Idle) && (dropCountReg != 16'hFFFF)) begin
                dropCountReg <= dropCountReg + 16'd1;
            end
            if ((state == Done) && satClamp) begin
                satFlagReg <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_upconvert_mixer.sv
// Directed self-checking bench for upconvert_mixer (SHIFT=18); DROP_COUNT_EN ports checked when defined.
module tb_upconvert_mixer;
    import upconvert_mixer_pkg::*;

    localparam int SHIFT = 18;
    localparam logic signed [17:0] MaxVal = 18'sh1FFFF;
    localparam logic signed [17:0] MinVal = 18'sh20000;

    logic          ipClk = 1'b0;
    logic          ipReset;
    COMPLEX_STREAM ipInput;
    COMPLEX_STREAM ipNCO;
    DATA_STREAM    opOutput;
    logic          opBusy;
`ifdef DROP_COUNT_EN
    logic [15:0]   opDropCount;
    logic          opSatFlag;
`endif

    int testCount = 0;
    int failCount = 0;

    always #5 ipClk = ~ipClk;

    upconvert_mixer #(.SHIFT(SHIFT)) dut (
        .ipClk    (ipClk),
        .ipReset  (ipReset),
        .ipInput  (ipInput),
        .ipNCO    (ipNCO),
        .opOutput (opOutput),
        .opBusy   (opBusy)
`ifdef DROP_COUNT_EN
        ,
        .opDropCount (opDropCount),
        .opSatFlag   (opSatFlag)
`endif
    );

    task automatic check(input string tag, input longint observed, input longint expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic longint refModel(input longint i, input longint q, input longint c, input longint s);
        longint p;
        longint r;
        p = i * c - q * s;
        r = (p + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
        if (r > 32767) return 32767;
        if (r < -32768) return -32768;
        return r;
    endfunction

    task automatic drive(input logic signed [17:0] i, input logic signed [17:0] q,
                         input logic signed [17:0] c, input logic signed [17:0] s, input logic v);
        ipInput.I     = i;
        ipInput.Q     = q;
        ipInput.Valid = v;
        ipNCO.I       = c;
        ipNCO.Q       = s;
        ipNCO.Valid   = 1'b0;
    endtask

    // One sample: latency, busy width, data value and single-cycle pulse.
    task automatic runSample(input string tag, input logic signed [17:0] i, input logic signed [17:0] q,
                             input logic signed [17:0] c, input logic signed [17:0] s, input longint expData);
        int lat;
        int busyCycles;
        @(negedge ipClk);
        drive(i, q, c, s, 1'b1);
        @(negedge ipClk);
        ipInput.Valid = 1'b0;
        lat = 0;
        busyCycles = 0;
        while (!opOutput.Valid && lat < 10) begin
            if (opBusy) busyCycles++;
            @(negedge ipClk);
            lat++;
        end
        check({tag, "_latency"}, lat, 3);
        check({tag, "_busy"}, busyCycles, 3);
        check({tag, "_data"}, longint'($signed(opOutput.Data)), expData);
        @(negedge ipClk);
        check({tag, "_pulse"}, longint'(opOutput.Valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint outs[$];
        longint expQ[$];
        int     seen;
        int     matched;
        logic signed [17:0] ri, rq, rc, rs;

        ipReset = 1'b1;
        drive(18'sd0, 18'sd0, 18'sd0, 18'sd0, 1'b0);
        repeat (2) @(negedge ipClk);
        check("rst_valid", longint'(opOutput.Valid), 0);
        check("rst_data", longint'($signed(opOutput.Data)), 0);
        check("rst_busy", longint'(opBusy), 0);
`ifdef DROP_COUNT_EN
        check("rst_drop", longint'(opDropCount), 0);
        check("rst_sat", longint'(opSatFlag), 0);
`endif
        ipReset = 1'b0;

        runSample("basic", 18'sd32768, 18'sd0, 18'sd131071, 18'sd0, 16384);
        runSample("subpath", 18'sd0, 18'sd32768, 18'sd0, 18'sd131071, -16384);
`ifdef DROP_COUNT_EN
        check("sat_flag_clear", longint'(opSatFlag), 0);
`endif
        runSample("sat_hi", MaxVal, MinVal, MaxVal, MaxVal, 32767);
`ifdef DROP_COUNT_EN
        check("sat_flag_set", longint'(opSatFlag), 1);
`endif
        runSample("sat_lo", MinVal, MaxVal, MaxVal, MaxVal, -32768);

        // Overrun: Valid held for 8 cycles, only samples 1 and 5 are taken.
        for (int k = 0; k < 20; k++) begin
            @(negedge ipClk);
            if (opOutput.Valid) outs.push_back(longint'($signed(opOutput.Data)));
            if (k < 8) drive(18'(100 * (k + 1)), 18'sd0, 18'sd131071, 18'sd0, 1'b1);
            else ipInput.Valid = 1'b0;
        end
        check("overrun_count", outs.size(), 2);
        while (outs.size() < 2) outs.push_back(-1);
        check("overrun_first", outs[0], 50);
        check("overrun_second", outs[1], 250);
`ifdef DROP_COUNT_EN
        check("overrun_drops", longint'(opDropCount), 6);
`endif

        // Reset asserted between edges while in Sub.
        @(negedge ipClk);
        drive(18'sd32768, 18'sd0, 18'sd131071, 18'sd0, 1'b1);
        @(negedge ipClk);
        ipInput.Valid = 1'b0;
        @(negedge ipClk);
        check("midrst_busy_before", longint'(opBusy), 1);
        #2 ipReset = 1'b1;
        #1;
        check("midrst_valid", longint'(opOutput.Valid), 0);
        check("midrst_data", longint'($signed(opOutput.Data)), 0);
        check("midrst_busy", longint'(opBusy), 0);
`ifdef DROP_COUNT_EN
        check("midrst_drop", longint'(opDropCount), 0);
        check("midrst_sat", longint'(opSatFlag), 0);
`endif
        @(negedge ipClk);
        ipReset = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge ipClk);
            if (opOutput.Valid) seen++;
        end
        check("midrst_no_pulse", seen, 0);
        runSample("after_rst", 18'sd500, 18'sd0, 18'sd131071, 18'sd0, 250);

        // Stream: one random sample every 4th cycle against the reference model.
        matched = 0;
        for (int cyc = 0; cyc < 64 * 4 + 8; cyc++) begin
            @(negedge ipClk);
            if (opOutput.Valid) begin
                if (expQ.size() > 0) begin
                    check("stream_data", longint'($signed(opOutput.Data)), expQ.pop_front());
                    matched++;
                end else begin
                    check("stream_extra", 1, 0);
                end
            end
            if ((cyc % 4 == 0) && (cyc < 64 * 4)) begin
                ri = 18'($urandom);
                rq = 18'($urandom);
                rc = 18'($urandom);
                rs = 18'($urandom);
                expQ.push_back(refModel(ri, rq, rc, rs));
                drive(ri, rq, rc, rs, 1'b1);
            end else begin
                ipInput.Valid = 1'b0;
            end
        end
        check("stream_matched", matched, 64);
        check("stream_left", expQ.size(), 0);
`ifdef DROP_COUNT_EN
        check("stream_drops", longint'(opDropCount), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
